// File: rtl/button_repeat_conditioner.sv
// Push-button conditioner for the clock/alarm mode FSM.
// Each raw button is synchronised, debounced, turned into a press pulse and,
// for the adjust buttons, auto-repeated while held. One command per cycle.
module button_repeat_conditioner #(
    parameter int         DEBOUNCE_TICKS = 4,
    parameter int         HOLD_TICKS     = 100,
    parameter int         REPEAT_TICKS   = 40,
    parameter logic [4:0] REPEAT_MASK    = 5'b11000
) (
    input  logic       clk200Hz,
    input  logic       rst,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_pulse,
    output logic [4:0] btn_level,
    output logic       any_pulse
);

    localparam int         NBTN      = 5;
    localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_TICKS - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);
    localparam logic [7:0] REP_LAST  = 8'(REPEAT_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic [4:0] sync_p0;
    logic [4:0] sync_p1;
    logic [7:0] dcnt      [NBTN];
    state_t     state     [NBTN];
    state_t     state_nxt [NBTN];
    logic [7:0] rcnt      [NBTN];
    logic [7:0] rcnt_nxt  [NBTN];
    logic [4:0] req;
    logic [4:0] grant;

    // Two-flop synchroniser for the asynchronous button pins
    always_ff @(posedge clk200Hz or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: a new level is accepted only after it persists DEBOUNCE_TICKS cycles
    always_ff @(posedge clk200Hz or posedge rst) begin
        if (rst) begin
            btn_level <= '0;
            for (int i = 0; i < NBTN; i++) dcnt[i] <= '0;
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                if (sync_p1[i] == btn_level[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DEB_LAST) begin
                    btn_level[i] <= ~btn_level[i];
                    dcnt[i]      <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 8'd1;
                end
            end
        end
    end

    // Per-button FSM state and hold/repeat counter registers
    always_ff @(posedge clk200Hz or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NBTN; i++) begin
                state[i] <= IDLE;
                rcnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                state[i] <= state_nxt[i];
                rcnt[i]  <= rcnt_nxt[i];
            end
        end
    end

    // Next-state: release always wins; non-repeating buttons park their counter
    always_comb begin
        for (int i = 0; i < NBTN; i++) begin
            state_nxt[i] = state[i];
            rcnt_nxt[i]  = rcnt[i];
            case (state[i])
                IDLE: begin
                    if (btn_level[i]) begin
                        state_nxt[i] = HOLD;
                        rcnt_nxt[i]  = '0;
                    end
                end
                HOLD: begin
                    if (!btn_level[i]) begin
                        state_nxt[i] = IDLE;
                        rcnt_nxt[i]  = '0;
                    end else if (REPEAT_MASK[i]) begin
                        if (rcnt[i] == HOLD_LAST) begin
                            state_nxt[i] = REPEAT;
                            rcnt_nxt[i]  = '0;
                        end else begin
                            rcnt_nxt[i] = rcnt[i] + 8'd1;
                        end
                    end else if (rcnt[i] != HOLD_LAST) begin
                        rcnt_nxt[i] = rcnt[i] + 8'd1;
                    end
                end
                REPEAT: begin
                    if (!btn_level[i]) begin
                        state_nxt[i] = IDLE;
                        rcnt_nxt[i]  = '0;
                    end else if (rcnt[i] == REP_LAST) begin
                        rcnt_nxt[i] = '0;
                    end else begin
                        rcnt_nxt[i] = rcnt[i] + 8'd1;
                    end
                end
                default: begin
                    state_nxt[i] = IDLE;
                    rcnt_nxt[i]  = '0;
                end
            endcase
        end
    end

    // Pulse requests: on the accepted press and whenever a threshold is reached
    always_comb begin
        req = '0;
        for (int i = 0; i < NBTN; i++) begin
            case (state[i])
                IDLE:    req[i] = btn_level[i];
                HOLD:    req[i] = btn_level[i] && REPEAT_MASK[i] && (rcnt[i] == HOLD_LAST);
                REPEAT:  req[i] = btn_level[i] && (rcnt[i] == REP_LAST);
                default: req[i] = 1'b0;
            endcase
        end
    end

    // Lowest index wins (C>R>L>U>D); losing requests are simply dropped
    assign grant = req & (~req + 5'd1);

    // Registered command outputs
    always_ff @(posedge clk200Hz or posedge rst) begin
        if (rst) begin
            btn_pulse <= '0;
            any_pulse <= 1'b0;
        end else begin
            btn_pulse <= grant;
            any_pulse <= |req;
        end
    end

endmodule

// File: tb/tb_button_repeat_conditioner.sv
// Directed bench for button_repeat_conditioner: reset, clean press, bounce,
// auto-repeat, simultaneous presses and reset while a button is held.
module tb_button_repeat_conditioner;

    logic       clk200Hz = 1'b0;
    logic       rst;
    logic [4:0] btn_raw;
    logic [4:0] btn_pulse;
    logic [4:0] btn_level;
    logic       any_pulse;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk200Hz = ~clk200Hz;

    button_repeat_conditioner dut (
        .clk200Hz  (clk200Hz),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_pulse (btn_pulse),
        .btn_level (btn_level),
        .any_pulse (any_pulse)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk200Hz);
        #1;
    endtask

    task automatic check_outs(input string tag, input int t, input logic [4:0] ep, input logic [4:0] el);
        string s;
        s = $sformatf("%s[%0d]", tag, t);
        check({s, " pulse"}, {3'b0, btn_pulse}, {3'b0, ep});
        check({s, " level"}, {3'b0, btn_level}, {3'b0, el});
        check({s, " any"},   {7'b0, any_pulse}, {7'b0, |ep});
    endtask

    // Press one button at t=0 (first sampled at edge 1), release after cycle hold
    task automatic hold_test(input string tag, input int idx, input int hold, input int total, input bit rep);
        logic [4:0] b;
        logic [4:0] ep;
        logic [4:0] el;
        b = 5'b00001 << idx;
        btn_raw = b;
        for (int t = 1; t <= total; t++) begin
            tick;
            ep = '0;
            if (t == 7) ep = b;
            if (rep && t >= 107 && t <= hold + 6 && ((t - 107) % 40) == 0) ep = b;
            el = (t >= 6 && t <= hold + 5) ? b : 5'b0;
            check_outs(tag, t, ep, el);
            if (t == hold) btn_raw = '0;
        end
    endtask

    initial begin
        logic [4:0] ep;
        logic [4:0] el;
        logic       r;

        // 1: reset, then idle
        rst     = 1'b1;
        btn_raw = '0;
        tick;
        tick;
        check_outs("t1_rst", 0, 5'b0, 5'b0);
        rst = 1'b0;
        for (int t = 1; t <= 50; t++) begin
            tick;
            check_outs("t1_idle", t, 5'b0, 5'b0);
        end

        // 2: clean C press held 20 cycles
        hold_test("t2_c", 0, 20, 30, 1'b0);

        // 3: R bounces in 3-cycle segments, steady high from sample 13
        for (int t = 1; t <= 50; t++) begin
            r = (t <= 3) || (t >= 7 && t <= 9) || (t >= 13 && t <= 40);
            btn_raw = {3'b0, r, 1'b0};
            tick;
            ep = (t == 19) ? 5'b00010 : 5'b0;
            el = (t >= 18 && t <= 45) ? 5'b00010 : 5'b0;
            check_outs("t3_r", t, ep, el);
        end
        btn_raw = '0;

        // 4: U auto-repeats, L does not
        hold_test("t4_u", 3, 300, 310, 1'b1);
        hold_test("t4_l", 2, 300, 310, 1'b0);

        // 5: C and U together; C wins the press, U still repeats
        btn_raw = 5'b01001;
        for (int t = 1; t <= 165; t++) begin
            tick;
            ep = '0;
            if (t == 7) ep = 5'b00001;
            if (t == 107 || t == 147) ep = 5'b01000;
            el = '0;
            if (t >= 6 && t <= 25)  el[0] = 1'b1;
            if (t >= 6 && t <= 155) el[3] = 1'b1;
            check_outs("t5_cu", t, ep, el);
            if (t == 20)  btn_raw[0] = 1'b0;
            if (t == 150) btn_raw[3] = 1'b0;
        end

        // 6: D held through a 2-cycle reset
        btn_raw = 5'b10000;
        for (int t = 1; t <= 260; t++) begin
            tick;
            ep = (t == 7 || t == 107 || t == 129 || t == 229) ? 5'b10000 : 5'b0;
            el = ((t >= 6 && t <= 120) || (t >= 128 && t <= 245)) ? 5'b10000 : 5'b0;
            check_outs("t6_d", t, ep, el);
            if (t == 120) begin
                rst = 1'b1;
                #1;
                check_outs("t6_in_rst", t, 5'b0, 5'b0);
            end
            if (t == 122) rst = 1'b0;
            if (t == 240) btn_raw = '0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
